// File: rtl/bitmask_idx_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bitmask_idx_serializer: drains a multi-hot mask as one index per cycle,  |
// | in ascending DIRECTION-numbered order. Rev 1.0                           |
// +--------------------------------------------------------------------------+
module bitmask_idx_serializer #(
  parameter int NUM_SIGNALS = 4,
  parameter     DIRECTION   = "LSB0",
  parameter int INDEX_WIDTH = $clog2(NUM_SIGNALS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_SIGNALS-1:0] in_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic [NUM_SIGNALS-1:0] out_one_hot,
  output logic                   out_last
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam bit                   C_MSB0 = (DIRECTION == "MSB0");
  localparam logic [INDEX_WIDTH-1:0] C_MAX_POS = INDEX_WIDTH'(NUM_SIGNALS - 1);
  localparam logic [NUM_SIGNALS-1:0] C_ONE     = NUM_SIGNALS'(1);

  state_e                 state_q;
  logic [NUM_SIGNALS-1:0] remaining_q;

  logic [INDEX_WIDTH-1:0] cur_pos;
  logic [NUM_SIGNALS-1:0] cur_one_hot;
  logic [INDEX_WIDTH-1:0] cur_index;
  logic                   cur_last;
  logic                   draining;
  logic                   in_fire;
  logic                   out_fire;

  // LSB0 drains from the lowest set bit upward, MSB0 from the highest down,
  // so the emitted index numbering is ascending in both cases.
  always_comb begin
    cur_pos = '0;
    if (C_MSB0) begin
      for (int i = 0; i < NUM_SIGNALS; i++) begin
        if (remaining_q[i]) cur_pos = INDEX_WIDTH'(i);
      end
    end else begin
      for (int i = NUM_SIGNALS - 1; i >= 0; i--) begin
        if (remaining_q[i]) cur_pos = INDEX_WIDTH'(i);
      end
    end
  end

  assign cur_one_hot = C_ONE << cur_pos;
  assign cur_index   = C_MSB0 ? (C_MAX_POS - cur_pos) : cur_pos;
  assign cur_last    = ((remaining_q & (remaining_q - C_ONE)) == '0);

  assign draining    = (state_q == DRAIN);
  assign out_valid   = draining;
  assign out_index   = draining ? cur_index   : '0;
  assign out_one_hot = draining ? cur_one_hot : '0;
  assign out_last    = draining & cur_last;

  assign out_fire    = out_valid & out_ready;
  assign in_ready    = !reset & ((state_q == IDLE) | (out_fire & out_last));
  assign in_fire     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A zero mask is accepted and dropped without producing output.
          if (in_fire && (in_mask != '0)) begin
            remaining_q <= in_mask;
            state_q     <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (!cur_last) begin
              remaining_q <= remaining_q & ~cur_one_hot;
            end else if (in_fire && (in_mask != '0)) begin
              remaining_q <= in_mask;
            end else begin
              remaining_q <= '0;
              state_q     <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          remaining_q <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bitmask_idx_serializer.sv
`default_nettype none
// Directed bench for bitmask_idx_serializer: LSB0/MSB0 at width 4, LSB0 at width 5.
module tb_bitmask_idx_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Instance A: NUM_SIGNALS=4, LSB0
  logic       a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_out_last;
  logic [3:0] a_in_mask = '0, a_out_one_hot;
  logic [1:0] a_out_index;
  // Instance B: NUM_SIGNALS=4, MSB0
  logic       b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_last;
  logic [3:0] b_in_mask = '0, b_out_one_hot;
  logic [1:0] b_out_index;
  // Instance C: NUM_SIGNALS=5, LSB0
  logic       c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0, c_out_last;
  logic [4:0] c_in_mask = '0, c_out_one_hot;
  logic [2:0] c_out_index;

  bitmask_idx_serializer #(.NUM_SIGNALS(4), .DIRECTION("LSB0")) u_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_mask(a_in_mask), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_index(a_out_index), .out_one_hot(a_out_one_hot), .out_last(a_out_last));

  bitmask_idx_serializer #(.NUM_SIGNALS(4), .DIRECTION("MSB0")) u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_mask(b_in_mask), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_index(b_out_index), .out_one_hot(b_out_one_hot), .out_last(b_out_last));

  bitmask_idx_serializer #(.NUM_SIGNALS(5), .DIRECTION("LSB0")) u_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_mask(c_in_mask), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_index(c_out_index), .out_one_hot(c_out_one_hot), .out_last(c_out_last));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_cmp++;
    if ({a_out_valid, a_out_index, a_out_one_hot, a_out_last, a_in_ready} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b idx=%0d oh=%b last=%b rdy=%b, want all 0",
               a_out_valid, a_out_index, a_out_one_hot, a_out_last, a_in_ready);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b v=%b, want rdy=1 v=0", a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_lsb0();
    logic [1:0] e_idx [3] = '{2'd0, 2'd1, 2'd3};
    logic [3:0] e_oh  [3] = '{4'b0001, 4'b0010, 4'b1000};
    logic       e_last[3] = '{1'b0, 1'b0, 1'b1};
    a_out_ready = 1'b1;
    a_in_mask   = 4'b1011;
    a_in_valid  = 1'b1;
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_out_index !== e_idx[i] || a_out_one_hot !== e_oh[i] ||
          a_out_last !== e_last[i]) begin
        n_fail++;
        $display("FAIL lsb0_beat%0d: got v=%b idx=%0d oh=%b last=%b, want v=1 idx=%0d oh=%b last=%b",
                 i, a_out_valid, a_out_index, a_out_one_hot, a_out_last, e_idx[i], e_oh[i], e_last[i]);
      end
      step();
    end
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lsb0_done: got v=%b rdy=%b, want v=0 rdy=1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_msb0();
    logic [1:0] e_idx [3] = '{2'd0, 2'd2, 2'd3};
    logic [3:0] e_oh  [3] = '{4'b1000, 4'b0010, 4'b0001};
    logic       e_last[3] = '{1'b0, 1'b0, 1'b1};
    b_out_ready = 1'b1;
    b_in_mask   = 4'b1011;
    b_in_valid  = 1'b1;
    step();
    b_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (b_out_valid !== 1'b1 || b_out_index !== e_idx[i] || b_out_one_hot !== e_oh[i] ||
          b_out_last !== e_last[i]) begin
        n_fail++;
        $display("FAIL msb0_beat%0d: got v=%b idx=%0d oh=%b last=%b, want v=1 idx=%0d oh=%b last=%b",
                 i, b_out_valid, b_out_index, b_out_one_hot, b_out_last, e_idx[i], e_oh[i], e_last[i]);
      end
      step();
    end
    n_cmp++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL msb0_done: got v=%b rdy=%b, want v=0 rdy=1", b_out_valid, b_in_ready);
    end
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    a_in_mask   = 4'b0110;
    a_in_valid  = 1'b1;
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_out_index !== 2'd1 || a_out_one_hot !== 4'b0010 ||
          a_out_last !== 1'b0 || a_in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall%0d: got v=%b idx=%0d oh=%b last=%b rdy=%b, want v=1 idx=1 oh=0010 last=0 rdy=0",
                 i, a_out_valid, a_out_index, a_out_one_hot, a_out_last, a_in_ready);
      end
      step();
    end
    a_out_ready = 1'b1;
    #1;
    n_cmp++;
    if (a_out_index !== 2'd1 || a_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got idx=%0d rdy=%b, want idx=1 rdy=0", a_out_index, a_in_ready);
    end
    step();
    n_cmp++;
    if (a_out_valid !== 1'b1 || a_out_index !== 2'd2 || a_out_one_hot !== 4'b0100 ||
        a_out_last !== 1'b1 || a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_last: got v=%b idx=%0d oh=%b last=%b rdy=%b, want v=1 idx=2 oh=0100 last=1 rdy=1",
               a_out_valid, a_out_index, a_out_one_hot, a_out_last, a_in_ready);
    end
    step();
    n_cmp++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_done: got v=%b, want v=0", a_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    a_out_ready = 1'b1;
    a_in_mask   = 4'b0000;
    a_in_valid  = 1'b1;
    step();
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_mask: got v=%b rdy=%b, want v=0 rdy=1", a_out_valid, a_in_ready);
    end
    a_in_mask = 4'b0100;
    step();
    n_cmp++;
    if (a_out_valid !== 1'b1 || a_out_index !== 2'd2 || a_out_last !== 1'b1 || a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: got v=%b idx=%0d last=%b rdy=%b, want v=1 idx=2 last=1 rdy=1",
               a_out_valid, a_out_index, a_out_last, a_in_ready);
    end
    a_in_mask = 4'b1001;
    step();
    n_cmp++;
    if (a_out_valid !== 1'b1 || a_out_index !== 2'd0 || a_out_one_hot !== 4'b0001 ||
        a_out_last !== 1'b0 || a_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: got v=%b idx=%0d oh=%b last=%b rdy=%b, want v=1 idx=0 oh=0001 last=0 rdy=0",
               a_out_valid, a_out_index, a_out_one_hot, a_out_last, a_in_ready);
    end
    a_in_valid = 1'b0;
    step();
    n_cmp++;
    if (a_out_valid !== 1'b1 || a_out_index !== 2'd3 || a_out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_third: got v=%b idx=%0d last=%b, want v=1 idx=3 last=1",
               a_out_valid, a_out_index, a_out_last);
    end
    step();
    n_cmp++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done: got v=%b, want v=0", a_out_valid);
    end
  endtask

  task automatic test_reset_mid_drain();
    a_out_ready = 1'b1;
    a_in_mask   = 4'b1111;
    a_in_valid  = 1'b1;
    step();
    a_in_valid = 1'b0;
    step();
    n_cmp++;
    if (a_out_valid !== 1'b1 || a_out_index !== 2'd1) begin
      n_fail++;
      $display("FAIL mid_idx1: got v=%b idx=%0d, want v=1 idx=1", a_out_valid, a_out_index);
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_out_index !== 2'd0) begin
        n_fail++;
        $display("FAIL mid_reset%0d: got v=%b rdy=%b idx=%0d, want v=0 rdy=0 idx=0",
                 i, a_out_valid, a_in_ready, a_out_index);
      end
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_release: got rdy=%b v=%b, want rdy=1 v=0", a_in_ready, a_out_valid);
    end
    step();
    n_cmp++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_residue: got v=%b idx=%0d, want v=0", a_out_valid, a_out_index);
    end
  endtask

  task automatic test_width5();
    c_out_ready = 1'b1;
    c_in_mask   = 5'b10001;
    c_in_valid  = 1'b1;
    step();
    c_in_valid = 1'b0;
    n_cmp++;
    if (c_out_valid !== 1'b1 || c_out_index !== 3'd0 || c_out_one_hot !== 5'b00001 || c_out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL w5_first: got v=%b idx=%0d oh=%b last=%b, want v=1 idx=0 oh=00001 last=0",
               c_out_valid, c_out_index, c_out_one_hot, c_out_last);
    end
    step();
    n_cmp++;
    if (c_out_valid !== 1'b1 || c_out_index !== 3'd4 || c_out_one_hot !== 5'b10000 || c_out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL w5_second: got v=%b idx=%0d oh=%b last=%b, want v=1 idx=4 oh=10000 last=1",
               c_out_valid, c_out_index, c_out_one_hot, c_out_last);
    end
    step();
    n_cmp++;
    if (c_out_valid !== 1'b0 || c_out_index !== 3'd0 || c_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL w5_done: got v=%b idx=%0d rdy=%b, want v=0 idx=0 rdy=1",
               c_out_valid, c_out_index, c_in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_lsb0();
    test_msb0();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_drain();
    test_width5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
